// File: rtl/qspi_psram_pkg.sv
// Shared types and protocol constants for the QSPI PSRAM emulator.
package qspi_psram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_READ,
        ST_WRITE,
        ST_IGNORE
    } state_t;

    localparam logic [7:0] CMD_WRITE_QUAD = 8'h38;
    localparam logic [7:0] CMD_WRITE      = 8'h02;
    localparam logic [7:0] CMD_READ_QUAD  = 8'hEB;
    localparam logic [7:0] CMD_READ       = 8'h0B;

    localparam int ADDR_NIBBLES = 6;

    function automatic logic is_write_cmd(input logic [7:0] cmd);
        return (cmd == CMD_WRITE_QUAD) || (cmd == CMD_WRITE);
    endfunction

    function automatic logic is_read_cmd(input logic [7:0] cmd);
        return (cmd == CMD_READ_QUAD) || (cmd == CMD_READ);
    endfunction

endpackage

// File: rtl/qspi_psram_mem.sv
// Single-port byte RAM with synchronous write and combinational read.
// No reset on the array so contents survive every reset of the emulator.
module qspi_psram_mem #(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [7:0]           wdata,
    output logic [7:0]           rdata
);

    logic [7:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/qspi_psram.sv
// System-clocked QSPI PSRAM emulator: quad write/read decode over an internal byte array.
// Optional sticky error output enabled by defining QSPI_PSRAM_ERR_EN.
//
// state     | meaning
// ST_IDLE   | CS high, outputs idle
// ST_CMD    | collecting the two command nibbles
// ST_ADDR   | collecting the six address nibbles
// ST_DUMMY  | counting dummy spi_clk rises before read data
// ST_READ   | driving mem[ptr] nibbles on spi_clk falls
// ST_WRITE  | storing nibble pairs on spi_clk rises
// ST_IGNORE | unknown command, wait for CS to rise
module qspi_psram
    import qspi_psram_pkg::*;
#(
    parameter int ADDR_BITS    = 12,
    parameter int DUMMY_CYCLES = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_clk,
    input  logic       spi_cs_n,
    input  logic [3:0] spi_data_in,
    input  logic [3:0] spi_data_oe,
    output logic [3:0] spi_data_out,
    output logic       spi_drive
`ifdef QSPI_PSRAM_ERR_EN
    ,
    output logic       err
`endif
);

    localparam logic [ADDR_BITS-1:0] PTR_ONE = 1;

    state_t               state_q, state_d;
    logic                 prev_sclk_q;
    logic [2:0]           nib_cnt_q, nib_cnt_d;
    logic [23:0]          shift_q, shift_d;
    logic                 is_write_q, is_write_d;
    logic [ADDR_BITS-1:0] ptr_q, ptr_d;
    logic [3:0]           hi_q, hi_d;
    logic                 half_q, half_d;
    logic [7:0]           dcnt_q, dcnt_d;
    logic [3:0]           dout_q, dout_d;
    logic                 drive_q, drive_d;

    logic                 rise, fall;
    logic [23:0]          shift_nib;
    logic [7:0]           cmd_byte;
    logic                 mem_we;
    logic [7:0]           mem_rdata;
    logic                 err_set;

    assign rise      = spi_clk & ~prev_sclk_q;
    assign fall      = ~spi_clk & prev_sclk_q;
    assign shift_nib = {shift_q[19:0], spi_data_in};
    assign cmd_byte  = shift_nib[7:0];

    qspi_psram_mem #(.ADDR_BITS(ADDR_BITS)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (ptr_q),
        .wdata ({hi_q, spi_data_in}),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            prev_sclk_q <= 1'b0;
            nib_cnt_q   <= '0;
            shift_q     <= '0;
            is_write_q  <= 1'b0;
            ptr_q       <= '0;
            hi_q        <= '0;
            half_q      <= 1'b0;
            dcnt_q      <= '0;
            dout_q      <= 4'hF;
            drive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_sclk_q <= spi_clk;
            nib_cnt_q   <= nib_cnt_d;
            shift_q     <= shift_d;
            is_write_q  <= is_write_d;
            ptr_q       <= ptr_d;
            hi_q        <= hi_d;
            half_q      <= half_d;
            dcnt_q      <= dcnt_d;
            dout_q      <= dout_d;
            drive_q     <= drive_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        nib_cnt_d  = nib_cnt_q;
        shift_d    = shift_q;
        is_write_d = is_write_q;
        ptr_d      = ptr_q;
        hi_d       = hi_q;
        half_d     = half_q;
        dcnt_d     = dcnt_q;
        dout_d     = dout_q;
        drive_d    = drive_q;
        mem_we     = 1'b0;
        err_set    = 1'b0;

        // CS high wins over any spi_clk edge and drops any half-collected byte
        if (spi_cs_n) begin
            state_d   = ST_IDLE;
            nib_cnt_d = '0;
            half_d    = 1'b0;
            dcnt_d    = '0;
            dout_d    = 4'hF;
            drive_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_CMD;
                    nib_cnt_d = '0;
                    half_d    = 1'b0;
                end
                ST_CMD: begin
                    if (rise) begin
                        shift_d = shift_nib;
                        if (nib_cnt_q == 3'd1) begin
                            nib_cnt_d = '0;
                            if (is_write_cmd(cmd_byte)) begin
                                is_write_d = 1'b1;
                                state_d    = ST_ADDR;
                            end else if (is_read_cmd(cmd_byte)) begin
                                is_write_d = 1'b0;
                                state_d    = ST_ADDR;
                            end else begin
                                state_d = ST_IGNORE;
                                err_set = 1'b1;
                            end
                        end else begin
                            nib_cnt_d = nib_cnt_q + 3'd1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rise) begin
                        shift_d = shift_nib;
                        if (nib_cnt_q == 3'(ADDR_NIBBLES - 1)) begin
                            nib_cnt_d = '0;
                            ptr_d     = shift_nib[ADDR_BITS-1:0];
                            half_d    = 1'b0;
                            dcnt_d    = 8'(DUMMY_CYCLES - 1);
                            err_set   = (shift_nib >> ADDR_BITS) != 24'd0;
                            if (is_write_q) begin
                                state_d = ST_WRITE;
                            end else if (DUMMY_CYCLES == 0) begin
                                state_d = ST_READ;
                            end else begin
                                state_d = ST_DUMMY;
                            end
                        end else begin
                            nib_cnt_d = nib_cnt_q + 3'd1;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (rise) begin
                        if (dcnt_q == 8'd0) begin
                            state_d = ST_READ;
                        end else begin
                            dcnt_d = dcnt_q - 8'd1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (rise) begin
                        if (!half_q) begin
                            hi_d   = spi_data_in;
                            half_d = 1'b1;
                        end else begin
                            mem_we = 1'b1;
                            ptr_d  = ptr_q + PTR_ONE;
                            half_d = 1'b0;
                        end
                    end
                end
                ST_READ: begin
                    if (fall) begin
                        drive_d = 1'b1;
                        if (!half_q) begin
                            dout_d = mem_rdata[7:4];
                            half_d = 1'b1;
                        end else begin
                            dout_d = mem_rdata[3:0];
                            ptr_d  = ptr_q + PTR_ONE;
                            half_d = 1'b0;
                        end
                    end
                end
                ST_IGNORE: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign spi_data_out = dout_q;
    assign spi_drive    = drive_q;

`ifdef QSPI_PSRAM_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_set || ((spi_data_oe != 4'h0) && drive_q)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_err;
    assign unused_err = err_set ^ (^spi_data_oe) ^ (^shift_nib[23:ADDR_BITS]);
`endif

endmodule

// File: tb/tb_qspi_psram.sv
// Directed plus randomized bench for qspi_psram against a byte-array reference model.
module tb_qspi_psram;

    localparam int AB    = 12;
    localparam int DC    = 6;
    localparam int DEPTH = 1 << AB;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_clk;
    logic       spi_cs_n;
    logic [3:0] spi_data_in;
    logic [3:0] spi_data_oe;
    logic [3:0] spi_data_out;
    logic       spi_drive;
`ifdef QSPI_PSRAM_ERR_EN
    logic       err;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] model [DEPTH];

    qspi_psram #(.ADDR_BITS(AB), .DUMMY_CYCLES(DC)) dut (
        .clk          (clk),
        .rst          (rst),
        .spi_clk      (spi_clk),
        .spi_cs_n     (spi_cs_n),
        .spi_data_in  (spi_data_in),
        .spi_data_oe  (spi_data_oe),
        .spi_data_out (spi_data_out),
        .spi_drive    (spi_drive)
`ifdef QSPI_PSRAM_ERR_EN
        ,
        .err          (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] n);
        spi_data_oe = 4'hF;
        spi_data_in = n;
        tick(); tick();
        spi_clk = 1'b1;
        tick(); tick();
        spi_clk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send(b[7:4]);
        send(b[3:0]);
    endtask

    task automatic recv(output logic [3:0] n, output logic d);
        spi_data_oe = 4'h0;
        spi_data_in = 4'h0;
        tick(); tick();
        n = spi_data_out;
        d = spi_drive;
        spi_clk = 1'b1;
        tick(); tick();
        spi_clk = 1'b0;
    endtask

    task automatic start(input logic [7:0] cmd, input logic [23:0] addr);
        spi_cs_n = 1'b0;
        tick(); tick();
        send_byte(cmd);
        for (int i = 5; i >= 0; i--) send(addr[i*4 +: 4]);
    endtask

    task automatic stop();
        spi_cs_n    = 1'b1;
        spi_clk     = 1'b0;
        spi_data_oe = 4'h0;
        tick(); tick(); tick();
    endtask

    task automatic do_write(input logic [7:0] cmd, input logic [23:0] addr,
                            input logic [7:0] d [4], input int len);
        start(cmd, addr);
        for (int i = 0; i < len; i++) begin
            send_byte(d[i]);
            model[(int'(addr[AB-1:0]) + i) % DEPTH] = d[i];
        end
        stop();
    endtask

    task automatic do_read(input string tag, input logic [7:0] cmd, input logic [23:0] addr,
                           input int len);
        logic [3:0] hi, lo;
        logic       d0, d1;
        start(cmd, addr);
        for (int i = 0; i < DC; i++) send(4'($urandom_range(0, 15)));
        for (int i = 0; i < len; i++) begin
            recv(hi, d0);
            recv(lo, d1);
            check({tag, "_data"}, {24'h0, hi, lo}, {24'h0, model[(int'(addr[AB-1:0]) + i) % DEPTH]});
            check({tag, "_drive"}, {30'h0, d0, d1}, 32'h3);
        end
        stop();
        check({tag, "_idle_drive"}, {31'h0, spi_drive}, 32'h0);
        check({tag, "_idle_out"}, {28'h0, spi_data_out}, 32'hF);
    endtask

    initial begin
        logic [7:0]  d [4];
        logic [3:0]  nib;
        logic        drv;
        logic [23:0] a;
        int          len;

        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
        rst = 1'b1; spi_clk = 1'b0; spi_cs_n = 1'b1; spi_data_in = 4'h0; spi_data_oe = 4'h0;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        check("reset_out", {28'h0, spi_data_out}, 32'hF);
        check("reset_drive", {31'h0, spi_drive}, 32'h0);
`ifdef QSPI_PSRAM_ERR_EN
        check("reset_err", {31'h0, err}, 32'h0);
`endif

        d = '{8'hA5, 8'h5A, 8'h00, 8'h00};
        do_write(8'h38, 24'h000010, d, 2);
        do_read("basic", 8'hEB, 24'h000010, 2);

        d = '{8'h11, 8'h22, 8'h00, 8'h00};
        do_write(8'h02, 24'h000FFF, d, 2);
        do_read("wrap_top", 8'h0B, 24'h000FFF, 1);
        do_read("wrap_zero", 8'hEB, 24'h000000, 1);

        start(8'h9F, 24'h000010);
        for (int i = 0; i < 4; i++) begin
            recv(nib, drv);
            check("ignore_drive", {31'h0, drv}, 32'h0);
            check("ignore_out", {28'h0, nib}, 32'hF);
        end
`ifdef QSPI_PSRAM_ERR_EN
        check("ignore_err", {31'h0, err}, 32'h1);
`endif
        stop();
        do_read("after_ignore", 8'hEB, 24'h000010, 2);

        d = '{8'hAB, 8'h00, 8'h00, 8'h00};
        do_write(8'h38, 24'h000020, d, 1);
        start(8'h38, 24'h000021);
        send(4'h7);
        stop();
        do_read("partial", 8'hEB, 24'h000020, 2);

        d = '{8'h5C, 8'h00, 8'h00, 8'h00};
        do_write(8'h38, 24'h000030, d, 1);
        rst = 1'b1; tick(); rst = 1'b0; tick();
        do_read("survive_rst", 8'hEB, 24'h000030, 1);

        start(8'hEB, 24'h000030);
        for (int i = 0; i < DC; i++) send(4'h0);
        recv(nib, drv);
        check("midread_nib", {28'h0, nib}, 32'h5);
        rst = 1'b1;
        #1;
        check("midread_rst_out", {28'h0, spi_data_out}, 32'hF);
        check("midread_rst_drive", {31'h0, spi_drive}, 32'h0);
        tick();
        rst = 1'b0;
        stop();

        for (int it = 0; it < 12; it++) begin
            a   = {12'h000, 12'($urandom_range(0, DEPTH - 1))};
            len = $urandom_range(1, 4);
            for (int k = 0; k < 4; k++) d[k] = 8'($urandom_range(0, 255));
            do_write(($urandom_range(0, 1) == 0) ? 8'h38 : 8'h02, a, d, len);
            if ($urandom_range(0, 2) == 0) a = {12'h000, 12'($urandom_range(0, DEPTH - 1))};
            do_read("rand", ($urandom_range(0, 1) == 0) ? 8'hEB : 8'h0B, a, $urandom_range(1, 4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
